// File: rtl/simd_booth_sequencer_pkg.sv
// simd_booth_pkg: shared definitions for the SIMD Booth multiplier sequencer.
//   - lane mode encodings driven on in_mode / mode
//   - FSM state codes (also visible on the sequencer's dbg_state port)
//   - per-mode iteration counts the datapath runs for
package simd_booth_pkg;

  // Lane mode encodings
  localparam logic [1:0] MODE_4X4   = 2'b00;  // four 4x4-bit lanes
  localparam logic [1:0] MODE_8X8   = 2'b01;  // two 8x8-bit lanes
  localparam logic [1:0] MODE_16X16 = 2'b10;  // one 16x16-bit lane
  localparam logic [1:0] MODE_RSVD  = 2'b11;  // reserved, rejected with an error

  // Sequencer state enumeration
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CLR  = 3'd1;
  localparam state_t ST_LDQ  = 3'd2;
  localparam state_t ST_RUN  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  // Iterations the datapath needs per mode
  localparam int ITER_4X4   = 4;
  localparam int ITER_8X8   = 8;
  localparam int ITER_16X16 = 16;

  function automatic logic [4:0] iter_count(input logic [1:0] mode);
    case (mode)
      MODE_4X4:   iter_count = 5'(ITER_4X4);
      MODE_8X8:   iter_count = 5'(ITER_8X8);
      MODE_16X16: iter_count = 5'(ITER_16X16);
      default:    iter_count = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/simd_booth_sequencer_watchdog.sv
// cycle_watchdog: counts RUN cycles and flags the cycle on which the count
// reaches TIMEOUT.
// Ports:
//   clk     - clock
//   clr     - synchronous active-high reset, clears the count
//   start   - clears the count (asserted the cycle before RUN is entered)
//   tick    - one RUN cycle elapsed
//   expired - high on the tick that brings the count to TIMEOUT
module cycle_watchdog #(
  parameter int TIMEOUT = 20
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Saturates at TIMEOUT so a stuck tick never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (clr || start) begin
      count <= '0;
    end else if (tick && (count != CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  // Combinational so the FSM can leave RUN on exactly the TIMEOUT-th cycle.
  assign expired = tick && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/simd_booth_sequencer.sv
// simd_booth_sequencer: control FSM for a SIMD Booth multiplier datapath.
// Accepts an operand pair, sequences datapath clear / load / iterate, and
// returns the product (or an error for reserved mode or a timeout).
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid is never withdrawn before the transfer and the payload
// holds while valid is high.
// Ports:
//   clk, clr                  - clock, synchronous active-high reset
//   in_valid/in_ready         - operand handshake
//   in_mode, in_M, in_Q       - lane mode, multiplicand, multiplier
//   mode, M, Q                - registered operands to the datapath
//   ld, dp_clr, dec, clr_count- datapath controls
//   eqz, result               - datapath done flag and product
//   out_valid/out_ready       - result handshake
//   out_result, out_err       - registered product, abort flag
//   busy                      - not IDLE
//   dbg_state                 - current FSM state
import simd_booth_pkg::*;

module simd_booth_sequencer #(
  parameter int TIMEOUT = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_mode,
  input  logic [15:0] in_M,
  input  logic [15:0] in_Q,
  output logic [1:0]  mode,
  output logic [15:0] M,
  output logic [15:0] Q,
  output logic        ld,
  output logic        dp_clr,
  output logic        dec,
  output logic        clr_count,
  input  logic        eqz,
  input  logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_err,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  state_t state;
  logic   wd_expired;

  cycle_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .clr     (clr),
    .start   (state == ST_LDQ),
    .tick    (state == ST_RUN),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      mode       <= 2'b00;
      M          <= 16'h0000;
      Q          <= 16'h0000;
      out_result <= 32'h0000_0000;
      out_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mode       <= in_mode;
            M          <= in_M;
            Q          <= in_Q;
            out_result <= 32'h0000_0000;
            if (in_mode == MODE_RSVD) begin
              out_err <= 1'b1;
              state   <= ST_DONE;
            end else begin
              out_err <= 1'b0;
              state   <= ST_CLR;
            end
          end
        end
        ST_CLR: state <= ST_LDQ;
        ST_LDQ: state <= ST_RUN;
        ST_RUN: begin
          // A completing datapath wins over a simultaneous timeout.
          if (eqz) begin
            out_result <= result;
            out_err    <= 1'b0;
            state      <= ST_DONE;
          end else if (wd_expired) begin
            out_result <= 32'h0000_0000;
            out_err    <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are gated by clr so an abort never shows a stray pulse in the
  // cycle clr is asserted; dp_clr doubles as the datapath reset.
  assign in_ready  = (state == ST_IDLE) && !clr;
  assign out_valid = (state == ST_DONE) && !clr;
  assign dp_clr    = clr || (state == ST_CLR);
  assign clr_count = (state == ST_CLR) && !clr;
  assign ld        = (state == ST_LDQ) && !clr;
  assign dec       = (state == ST_RUN) && !eqz && !clr;
  assign busy      = (state != ST_IDLE) && !clr;
  assign dbg_state = state;

endmodule

// File: doc/simd_booth_sequencer.md
SIMD_BOOTH_SEQUENCER -- requirements
Module: simd_booth_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 20: maximum RUN cycles before abort.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 clr  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  operand pair offered.
REQ-005 in_ready  out  1  sequencer can accept operands.
REQ-006 in_mode  in  2  lane mode: 00 = 4x4-bit x4, 01 = 8x8-bit x2, 10 = 16x16-bit x1, 11 = reserved.
REQ-007 in_M, in_Q  in  16 each  multiplicand and multiplier.
REQ-008 mode, M, Q  out  2/16/16  registered operands driven to the datapath.
REQ-009 ld, dp_clr, dec, clr_count  out  1 each  datapath controls: load Q, clear accumulator, decrement counter, reload counter.
REQ-010 eqz  in  1  datapath iteration-complete flag.
REQ-011 result  in  32  datapath product.
REQ-012 out_valid  out  1  product available; out_ready  in  1  consumer accepts.
REQ-013 out_result  out  32  registered product; out_err  out  1  reserved-mode or timeout abort.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, CLR, LDQ, RUN and DONE.
REQ-016 in_ready SHALL equal (state == IDLE) and depend on nothing else.
REQ-017 On in_valid & in_ready, in_M, in_Q and in_mode SHALL be latched into M, Q and mode, with a transition to CLR, or to DONE with out_err = 1 and out_result = 0 if in_mode = 11.
REQ-018 In CLR, dp_clr = 1 and clr_count = 1 for exactly one cycle, then LDQ.
REQ-019 In LDQ, ld = 1 for exactly one cycle, then RUN.
REQ-020 In RUN, dec SHALL be driven combinationally as the inverse of eqz.
REQ-021 When eqz = 1 is sampled in RUN, result SHALL be registered into out_result with out_err = 0, followed by a transition to DONE.
REQ-022 A RUN-cycle counter SHALL clear on entry to RUN; if it reaches TIMEOUT with eqz = 0, the FSM SHALL go to DONE with out_err = 1 and out_result = 0.
REQ-023 In DONE, out_valid = 1; out_result and out_err SHALL hold until out_valid & out_ready, then return to IDLE, so that in_ready rises the following cycle.
REQ-024 out_valid SHALL be low in every state except DONE; ld, dp_clr, dec and clr_count SHALL be low outside the states named above.
REQ-025 M, Q and mode SHALL remain stable from CLR through DONE.
REQ-026 Latency, with eqz rising after N dec cycles (N = 4/8/16 for mode 00/01/10): accept at cycle T gives out_valid at cycle T+4+N.
REQ-027 eqz asserted outside RUN SHALL be ignored.

Reset
REQ-028 While clr = 1: state = IDLE and dp_clr = 1; all other outputs 0 except in_ready, which is 0 during reset and 1 on the first cycle after clr falls; M, Q, mode, out_result and the timeout counter are 0.
REQ-029 clr asserted in any state, including mid-RUN or DONE, SHALL abort the operation with no out_valid pulse.

Structure
REQ-030 Shared package simd_booth_pkg SHALL hold the mode encodings, the state enumeration and the per-mode iteration counts (4/8/16).
REQ-031 The timeout counter SHALL be a sub-module named cycle_watchdog, with inputs clk, clr, start and tick and output expired.

Verification
REQ-032 Mode 01, M = 0x0305, Q = 0x0407, with a datapath model raising eqz after 8 dec pulses, accepted at cycle 0: out_valid at cycle 12, out_result = model result, out_err = 0.
REQ-033 Mode 11 offered: in_ready drops, out_valid is high on the next cycle with out_err = 1 and out_result = 0, and ld, dp_clr and dec are never pulsed.
REQ-034 Mode 10 with eqz held at 0: exactly 20 dec cycles, then DONE with out_err = 1.
REQ-035 out_ready held at 0 for 5 cycles in DONE: out_valid and out_result stable, in_ready = 0, and a new transaction is accepted the cycle after the handshake.
REQ-036 clr pulsed on the 3rd RUN cycle in mode 10: next cycle state = IDLE, out_valid = 0, in_ready = 1 one cycle after clr falls, and a subsequent mode 00 operation completes correctly.
